// File: rtl/code_decoder_3x8.sv
// code_decoder_3x8: 3-bit code stream to timed one-hot pulses.
// Codes enter over a valid/ready handshake into a small circular FIFO. Each
// code is popped and driven as a one-hot word for HOLD_CYCLES cycles. The
// pulse is followed by GAP_CYCLES all-zero cycles. With GAP_CYCLES=0, queued
// codes run back-to-back with no zero cycle between them.
// Optional feature macro: CODE_DECODER_STICKY_EN adds sticky_clr/sticky_mask.
// sticky_mask is the OR of every one-hot word driven since the last clear.
`timescale 1ns/1ps

module code_decoder_3x8 #(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 3,
  parameter int GAP_CYCLES  = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          in_valid,
  input  logic [2:0]                    in_code,
`ifdef CODE_DECODER_STICKY_EN
  input  logic                          sticky_clr,
  output logic [7:0]                    sticky_mask,
`endif
  output logic                          in_ready,
  output logic [7:0]                    out_onehot,
  output logic                          out_valid,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [7:0]    HOLD_L  = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0]    GAP_L   = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit            HAS_GAP = (GAP_CYCLES > 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // FIFO storage and pointers
  logic [2:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Output stage
  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    onehot_q, onehot_d;

  logic          push;
  logic          pop;
  logic [2:0]    head;
  logic [7:0]    head_onehot;

  // in_ready looks only at registered occupancy. A pop in the same cycle
  // does not open a slot until the next cycle.
  assign in_ready    = (count_q < DEPTH_C);
  assign push        = in_valid & in_ready & ~flush;
  assign head        = mem_q[rd_ptr_q];
  assign head_onehot = 8'h01 << head;

  // Sequencing of pulse, gap and idle, plus the pop request into the FIFO
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    onehot_d = onehot_q;
    pop      = 1'b0;
    unique case (state_q)
      IDLE: begin
        onehot_d = 8'h00;
        if (count_q != '0) begin
          pop      = 1'b1;
          onehot_d = head_onehot;
          cnt_d    = HOLD_L;
          state_d  = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (HAS_GAP) begin
          state_d  = GAP;
          onehot_d = 8'h00;
          cnt_d    = GAP_L;
        end else if (count_q != '0) begin
          // Back-to-back reload: the next word follows with no zero cycle
          pop      = 1'b1;
          onehot_d = head_onehot;
          cnt_d    = HOLD_L;
        end else begin
          state_d  = IDLE;
          onehot_d = 8'h00;
          cnt_d    = 8'd0;
        end
      end
      GAP: begin
        onehot_d = 8'h00;
        if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
        else               state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        onehot_d = 8'h00;
        cnt_d    = 8'd0;
      end
    endcase
    // flush abandons the pulse in flight and discards the queue
    if (flush) begin
      state_d  = IDLE;
      cnt_d    = 8'd0;
      onehot_d = 8'h00;
      pop      = 1'b0;
    end
  end

  // FIFO pointer and occupancy update. The pointers wrap naturally because
  // the depth is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // FIFO data write. The contents need no reset because the pointers
  // qualify them.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_code;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      onehot_q <= 8'h00;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      onehot_q <= onehot_d;
    end
  end

  assign out_onehot = onehot_q;
  assign out_valid  = (state_q == DRIVE);
  assign busy       = (state_q != IDLE) || (count_q != '0);
  assign fifo_count = count_q;

`ifdef CODE_DECODER_STICKY_EN
  logic [7:0] sticky_q, sticky_d;

  // Accumulate every driven word. Any clear source wins over accumulation.
  always_comb begin
    sticky_d = sticky_q | onehot_q;
    if (flush || sticky_clr) sticky_d = 8'h00;
  end

  // Sticky register
  always_ff @(posedge clk) begin
    if (!rst_n) sticky_q <= 8'h00;
    else        sticky_q <= sticky_d;
  end

  assign sticky_mask = sticky_q;
`endif

endmodule

// File: tb/tb_code_decoder_3x8.sv
// Directed bench for code_decoder_3x8: a default-parameter instance (u_dut)
// and a HOLD_CYCLES=2, GAP_CYCLES=0 instance (u_b) for back-to-back pulses.
// Outputs are sampled 1ns after each rising edge.
`timescale 1ns/1ps

module tb_code_decoder_3x8;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, flush, in_valid;
  logic [2:0] in_code;
  logic       in_ready, out_valid, busy;
  logic [7:0] out_onehot;
  logic [2:0] fifo_count;

  logic       b_in_valid;
  logic [2:0] b_in_code;
  logic       b_in_ready, b_out_valid, b_busy;
  logic [7:0] b_out_onehot;
  logic [2:0] b_fifo_count;

`ifdef CODE_DECODER_STICKY_EN
  logic       sticky_clr, b_sticky_clr;
  logic [7:0] sticky_mask, b_sticky_mask;
`endif

  code_decoder_3x8 #(.FIFO_DEPTH(4), .HOLD_CYCLES(3), .GAP_CYCLES(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_code(in_code),
`ifdef CODE_DECODER_STICKY_EN
    .sticky_clr(sticky_clr), .sticky_mask(sticky_mask),
`endif
    .in_ready(in_ready), .out_onehot(out_onehot), .out_valid(out_valid),
    .busy(busy), .fifo_count(fifo_count));

  code_decoder_3x8 #(.FIFO_DEPTH(4), .HOLD_CYCLES(2), .GAP_CYCLES(0)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(b_in_valid), .in_code(b_in_code),
`ifdef CODE_DECODER_STICKY_EN
    .sticky_clr(b_sticky_clr), .sticky_mask(b_sticky_mask),
`endif
    .in_ready(b_in_ready), .out_onehot(b_out_onehot), .out_valid(b_out_valid),
    .busy(b_busy), .fifo_count(b_fifo_count));

  int         nvec = 0;
  int         nerr = 0;
  logic [7:0] pulses[$];
  int         maxcnt = 0;
  bit         chk_len = 1'b1;
  int         run = 0;
  logic       prev_v = 1'b0;

  // Pulse monitor on u_dut: the word shape, the pulse order and the pulse length
  always @(negedge clk) begin
    nvec++;
    if (out_valid ? ($countones(out_onehot) != 1) : (out_onehot !== 8'h00)) begin
      nerr++;
      $display("FAIL onehot_shape: out_onehot=%h out_valid=%b", out_onehot, out_valid);
    end
    if (out_valid && !prev_v) pulses.push_back(out_onehot);
    if (out_valid) run++;
    else begin
      if (prev_v && chk_len) begin
        nvec++;
        if (run != 3) begin
          nerr++;
          $display("FAIL pulse_len: got %0d cycles, want 3", run);
        end
      end
      run = 0;
    end
    prev_v = out_valid;
    if (int'(fifo_count) > maxcnt) maxcnt = int'(fifo_count);
  end

  task automatic step;
    @(posedge clk); #1;
  endtask

  // Offer a code to u_dut and hold it until it is accepted. w returns the
  // number of cycles that were stalled.
  task automatic push_code(input logic [2:0] c, output int w);
    w = 0;
    in_valid = 1'b1; in_code = c;
    while (!in_ready && w < 100) begin step; w++; end
    if (w >= 100) begin
      nerr++; $display("FAIL push_timeout: in_ready=%b want 1", in_ready);
    end
    step;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle;
    int k = 0;
    while (busy && k < 300) begin step; k++; end
    nvec++;
    if (busy) begin nerr++; $display("FAIL drain_timeout: busy=%b want 0", busy); end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_code = 3'd0;
    b_in_valid = 1'b0; b_in_code = 3'd0;
`ifdef CODE_DECODER_STICKY_EN
    sticky_clr = 1'b0; b_sticky_clr = 1'b0;
`endif
    repeat (3) step;
    rst_n = 1'b1;
    nvec += 6;
    if (out_onehot !== 8'h00) begin nerr++; $display("FAIL rst_onehot: got %h want 00", out_onehot); end
    if (out_valid !== 1'b0)   begin nerr++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    if (busy !== 1'b0)        begin nerr++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (fifo_count !== 3'd0)  begin nerr++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
    if (in_ready !== 1'b1)    begin nerr++; $display("FAIL rst_ready: got %b want 1", in_ready); end
    if (b_fifo_count !== 3'd0) begin nerr++; $display("FAIL rst_b_count: got %0d want 0", b_fifo_count); end
`ifdef CODE_DECODER_STICKY_EN
    nvec++;
    if (sticky_mask !== 8'h00) begin nerr++; $display("FAIL rst_sticky: got %h want 00", sticky_mask); end
`endif
  endtask

  task automatic test_single;
    logic [7:0] eo [5] = '{8'h04, 8'h04, 8'h04, 8'h00, 8'h00};
    logic       ev [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       eb [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    pulses.delete();
    in_valid = 1'b1; in_code = 3'd2;
    step;
    in_valid = 1'b0;
    nvec += 3;
    if (fifo_count !== 3'd1)  begin nerr++; $display("FAIL single_cnt0: got %0d want 1", fifo_count); end
    if (out_onehot !== 8'h00) begin nerr++; $display("FAIL single_lat: got %h want 00", out_onehot); end
    if (busy !== 1'b1)        begin nerr++; $display("FAIL single_busy0: got %b want 1", busy); end
    for (int i = 0; i < 5; i++) begin
      step;
      nvec += 3;
      if (out_onehot !== eo[i]) begin nerr++; $display("FAIL single_onehot[%0d]: got %h want %h", i, out_onehot, eo[i]); end
      if (out_valid !== ev[i])  begin nerr++; $display("FAIL single_valid[%0d]: got %b want %b", i, out_valid, ev[i]); end
      if (busy !== eb[i])       begin nerr++; $display("FAIL single_busy[%0d]: got %b want %b", i, busy, eb[i]); end
    end
  endtask

  task automatic test_burst;
    logic [2:0] codes [4] = '{3'd0, 3'd4, 3'd7, 3'd1};
    logic [7:0] exp   [4] = '{8'h01, 8'h10, 8'h80, 8'h02};
    int w;
    pulses.delete();
    foreach (codes[i]) push_code(codes[i], w);
    nvec++;
    if (fifo_count !== 3'd3) begin nerr++; $display("FAIL burst_cnt: got %0d want 3", fifo_count); end
    wait_idle;
    nvec++;
    if (pulses.size() != 4) begin nerr++; $display("FAIL burst_num: got %0d want 4", pulses.size()); end
    for (int i = 0; i < 4 && i < pulses.size(); i++) begin
      nvec++;
      if (pulses[i] !== exp[i]) begin nerr++; $display("FAIL burst_order[%0d]: got %h want %h", i, pulses[i], exp[i]); end
    end
  endtask

  task automatic test_back_to_back_full;
    logic [2:0] codes [6] = '{3'd3, 3'd5, 3'd0, 3'd2, 3'd7, 3'd4};
    logic [7:0] exp   [6] = '{8'h08, 8'h20, 8'h01, 8'h04, 8'h80, 8'h10};
    int         ew    [6] = '{0, 0, 0, 0, 0, 2};
    int w;
    pulses.delete(); maxcnt = 0;
    foreach (codes[i]) begin
      push_code(codes[i], w);
      nvec++;
      if (w != ew[i]) begin nerr++; $display("FAIL full_stall[%0d]: got %0d want %0d", i, w, ew[i]); end
      if (i == 4) begin
        nvec += 2;
        if (fifo_count !== 3'd4) begin nerr++; $display("FAIL full_cnt: got %0d want 4", fifo_count); end
        if (in_ready !== 1'b0)   begin nerr++; $display("FAIL full_ready: got %b want 0", in_ready); end
      end
      if (i == 5) begin
        nvec++;
        if (fifo_count !== 3'd4) begin nerr++; $display("FAIL full_refill: got %0d want 4", fifo_count); end
      end
    end
    wait_idle;
    nvec += 2;
    if (maxcnt != 4) begin nerr++; $display("FAIL full_max: got %0d want 4", maxcnt); end
    if (pulses.size() != 6) begin nerr++; $display("FAIL full_num: got %0d want 6", pulses.size()); end
    for (int i = 0; i < 6 && i < pulses.size(); i++) begin
      nvec++;
      if (pulses[i] !== exp[i]) begin nerr++; $display("FAIL full_order[%0d]: got %h want %h", i, pulses[i], exp[i]); end
    end
  endtask

  task automatic test_gap0;
    logic [7:0] eo [5] = '{8'h20, 8'h20, 8'h40, 8'h40, 8'h00};
    logic       ev [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    b_in_valid = 1'b1; b_in_code = 3'd5;
    step;
    b_in_code = 3'd6;
    step;
    b_in_valid = 1'b0;
    nvec++;
    if (b_fifo_count !== 3'd1) begin nerr++; $display("FAIL gap0_cnt: got %0d want 1", b_fifo_count); end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step;
      nvec += 2;
      if (b_out_onehot !== eo[i]) begin nerr++; $display("FAIL gap0_onehot[%0d]: got %h want %h", i, b_out_onehot, eo[i]); end
      if (b_out_valid !== ev[i])  begin nerr++; $display("FAIL gap0_valid[%0d]: got %b want %b", i, b_out_valid, ev[i]); end
    end
  endtask

  task automatic test_flush;
    int w;
    chk_len = 1'b0;
    pulses.delete();
    push_code(3'd3, w);
    push_code(3'd1, w);
    push_code(3'd2, w);
    nvec += 2;
    if (out_onehot !== 8'h08) begin nerr++; $display("FAIL flush_pre: got %h want 08", out_onehot); end
    if (fifo_count !== 3'd2)  begin nerr++; $display("FAIL flush_precnt: got %0d want 2", fifo_count); end
    flush = 1'b1; in_valid = 1'b1; in_code = 3'd5;
    step;
    flush = 1'b0; in_valid = 1'b0;
    nvec += 4;
    if (out_onehot !== 8'h00) begin nerr++; $display("FAIL flush_onehot: got %h want 00", out_onehot); end
    if (out_valid !== 1'b0)   begin nerr++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    if (fifo_count !== 3'd0)  begin nerr++; $display("FAIL flush_cnt: got %0d want 0", fifo_count); end
    if (busy !== 1'b0)        begin nerr++; $display("FAIL flush_busy: got %b want 0", busy); end
    repeat (12) step;
    nvec += 2;
    if (pulses.size() != 1) begin nerr++; $display("FAIL flush_after: got %0d pulses want 1", pulses.size()); end
    if (fifo_count !== 3'd0) begin nerr++; $display("FAIL flush_lost: got %0d want 0", fifo_count); end
    chk_len = 1'b1;
  endtask

  task automatic test_reset_mid;
    int w;
    chk_len = 1'b0;
    push_code(3'd6, w);
    step;
    nvec++;
    if (out_onehot !== 8'h40) begin nerr++; $display("FAIL rmid_pre: got %h want 40", out_onehot); end
    rst_n = 1'b0; flush = 1'b1;
    step;
    rst_n = 1'b1; flush = 1'b0;
    nvec += 3;
    if (out_onehot !== 8'h00) begin nerr++; $display("FAIL rmid_onehot: got %h want 00", out_onehot); end
    if (busy !== 1'b0)        begin nerr++; $display("FAIL rmid_busy: got %b want 0", busy); end
    if (fifo_count !== 3'd0)  begin nerr++; $display("FAIL rmid_cnt: got %0d want 0", fifo_count); end
    repeat (4) step;
    nvec++;
    if (out_valid !== 1'b0) begin nerr++; $display("FAIL rmid_quiet: got %b want 0", out_valid); end
    chk_len = 1'b1;
  endtask

`ifdef CODE_DECODER_STICKY_EN
  task automatic test_sticky;
    int w;
    sticky_clr = 1'b1;
    step;
    sticky_clr = 1'b0;
    nvec++;
    if (sticky_mask !== 8'h00) begin nerr++; $display("FAIL sticky_init: got %h want 00", sticky_mask); end
    push_code(3'd1, w);
    push_code(3'd6, w);
    wait_idle;
    nvec++;
    if (sticky_mask !== 8'h42) begin nerr++; $display("FAIL sticky_acc: got %h want 42", sticky_mask); end
    sticky_clr = 1'b1;
    step;
    sticky_clr = 1'b0;
    nvec++;
    if (sticky_mask !== 8'h00) begin nerr++; $display("FAIL sticky_clr: got %h want 00", sticky_mask); end
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_burst;
    test_back_to_back_full;
    test_gap0;
    test_flush;
    test_reset_mid;
`ifdef CODE_DECODER_STICKY_EN
    test_sticky;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
